// File: rtl/clk_enable_gen.sv
// N-channel fractional (num/den NCO) clock-enable generator, gated by a qualified PLL lock.
// Optional `pause` input is compiled in when CLK_EN_GEN_PAUSE_EN is defined.

module clk_enable_lane #(
  parameter int AW = 16
) (
  input  logic          refclk,
  input  logic          rst_n,
  input  logic          active,
  input  logic          hold,
  input  logic          apply,
  input  logic [AW-1:0] ld_num,
  input  logic [AW-1:0] ld_den,
  input  logic [AW-1:0] ld_phase,
  output logic          den_zero,
  output logic          wrap,
  output logic          cen
);
  logic [AW-1:0] num, den, acc, phase, num_eff, acc_nxt, ld_load;
  logic [AW:0]   sum, diff;

  always_comb begin
    num_eff  = (num > den) ? den : num;
    sum      = {1'b0, acc} + {1'b0, num_eff};
    diff     = sum - {1'b0, den};
    den_zero = (den == '0);
    wrap     = active & ~hold & ~den_zero & (sum >= {1'b0, den});
    ld_load  = (ld_phase >= ld_den) ? '0 : ld_phase;
  end

  // Lock loss reloads the phase; pause freezes; den=0 parks the channel at zero.
  always_comb begin
    acc_nxt = acc;
    if (!active)       acc_nxt = phase;
    else if (hold)     acc_nxt = acc;
    else if (den_zero) acc_nxt = '0;
    else if (wrap)     acc_nxt = diff[AW-1:0];
    else               acc_nxt = sum[AW-1:0];
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      num   <= '0;
      den   <= '0;
      acc   <= '0;
      phase <= '0;
      cen   <= 1'b0;
    end else begin
      cen <= wrap;
      if (apply) begin
        num   <= ld_num;
        den   <= ld_den;
        acc   <= ld_load;
        phase <= ld_load;
      end else begin
        acc <= acc_nxt;
      end
    end
  end
endmodule

module clk_enable_gen #(
  parameter int CHANNELS   = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int LOCK_DELAY = 1024,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  input  logic                 locked,
`ifdef CLK_EN_GEN_PAUSE_EN
  input  logic                 pause,
`endif
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [ACC_WIDTH-1:0] cfg_num,
  input  logic [ACC_WIDTH-1:0] cfg_den,
  input  logic [ACC_WIDTH-1:0] cfg_phase,
  output logic [CHANNELS-1:0]  cen,
  output logic                 running
);
  localparam int CNT_W = $clog2(LOCK_DELAY + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_DELAY);

  typedef struct packed {
    logic [CH_W-1:0]      ch;
    logic [ACC_WIDTH-1:0] num;
    logic [ACC_WIDTH-1:0] den;
    logic [ACC_WIDTH-1:0] phase;
  } cfg_req_t;

  logic [1:0]          lock_sync;
  logic                locked_s, active, hold, accept, ch_ok, pend_vld;
  logic [CNT_W-1:0]    lock_cnt;
  cfg_req_t            pend_q;
  logic [CHANNELS-1:0] apply, wrap, den_zero;

`ifdef CLK_EN_GEN_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign locked_s  = lock_sync[1];
  assign running   = (lock_cnt == LOCK_MAX);
  // Gate on locked_s too so cen is already low on the edge where running falls.
  assign active    = running & locked_s;
  assign cfg_ready = ~pend_vld;
  assign accept    = cfg_valid & cfg_ready;
  assign ch_ok     = ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync <= '0;
      lock_cnt  <= '0;
    end else begin
      lock_sync <= {lock_sync[0], locked};
      if (!locked_s)                lock_cnt <= '0;
      else if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
    end
  end

  // Single pending slot; writes to nonexistent channels are swallowed without occupying it.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend_q   <= '0;
    end else if (|apply) begin
      pend_vld <= 1'b0;
    end else if (accept && ch_ok) begin
      pend_vld <= 1'b1;
      pend_q   <= '{ch: cfg_ch, num: cfg_num, den: cfg_den, phase: cfg_phase};
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    localparam logic [CH_W-1:0] IDX = CH_W'(i);
    assign apply[i] = pend_vld & (pend_q.ch == IDX) & (den_zero[i] | ~active | wrap[i]);

    clk_enable_lane #(.AW(ACC_WIDTH)) u_lane (
      .refclk   (refclk),
      .rst_n    (rst_n),
      .active   (active),
      .hold     (hold),
      .apply    (apply[i]),
      .ld_num   (pend_q.num),
      .ld_den   (pend_q.den),
      .ld_phase (pend_q.phase),
      .den_zero (den_zero[i]),
      .wrap     (wrap[i]),
      .cen      (cen[i])
    );
  end
endmodule

// File: tb/tb_clk_enable_gen.sv
// Randomized scoreboard bench for clk_enable_gen; the reference model works from
// closed-form NCO arithmetic (pulse when floor((p+k*n)/d) steps) and locked-sample history.

module tb_clk_enable_gen;
  localparam int CH = 3, AW = 16, L = 16, CHW = 2;

  logic refclk = 1'b0;
  logic rst_n, locked, cfg_valid, cfg_ready, running;
  logic [CHW-1:0] cfg_ch;
  logic [AW-1:0]  cfg_num, cfg_den, cfg_phase;
  logic [CH-1:0]  cen;
  bit pz = 1'b0;
`ifdef CLK_EN_GEN_PAUSE_EN
  logic pause;
  assign pause = pz;
`endif

  always #5 refclk = ~refclk;

  clk_enable_gen #(.CHANNELS(CH), .ACC_WIDTH(AW), .LOCK_DELAY(L)) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .locked    (locked),
`ifdef CLK_EN_GEN_PAUSE_EN
    .pause     (pause),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .cfg_phase (cfg_phase),
    .cen       (cen),
    .running   (running)
  );

  typedef struct { logic [CH-1:0] cen; bit run; bit rdy; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int win_cnt = 0;
  bit win = 1'b0;

  // Reference model state
  longint m_n[CH], m_d[CH], m_p[CH], m_k[CH];
  bit     m_pend;
  int     m_pch;
  longint m_pn, m_pd, m_pp;
  bit     lk_hist[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Length of the run of locked=1 samples ending two edges ago (sync latency).
  function automatic int ones_run();
    int c = 0;
    for (int j = lk_hist.size() - 2; j >= 0; j--) begin
      if (lk_hist[j]) c++;
      else break;
    end
    return c;
  endfunction

  function automatic bit wraps(input int i);
    longint ne, a;
    ne = (m_n[i] < m_d[i]) ? m_n[i] : m_d[i];
    a  = m_p[i] + m_k[i] * ne;
    return ((a + ne) / m_d[i]) != (a / m_d[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_n[i] = 0; m_d[i] = 0; m_p[i] = 0; m_k[i] = 0;
    end
    m_pend = 1'b0;
    lk_hist.delete();
    lk_hist.push_back(1'b0);
    lk_hist.push_back(1'b0);
  endtask

  // Predict outputs after the upcoming edge from the current inputs.
  task automatic step();
    exp_t e;
    logic [CH-1:0] w;
    bit act, runa;
    int r;
    w = '0;
    if (!rst_n) begin
      model_reset();
      e.cen = '0; e.run = 1'b0; e.rdy = 1'b1;
    end else begin
      r    = ones_run();
      act  = (r >= L + 1);
      runa = (r >= L);
      for (int i = 0; i < CH; i++) begin
        w[i] = act && !pz && (m_d[i] != 0) && wraps(i);
        if (!act)           m_k[i] = 0;
        else if (pz)        m_k[i] = m_k[i];
        else if (m_d[i] == 0) m_k[i] = 0;
        else                m_k[i] = m_k[i] + 1;
      end
      if (m_pend && (m_d[m_pch] == 0 || !act || w[m_pch])) begin
        m_n[m_pch] = m_pn;
        m_d[m_pch] = m_pd;
        m_p[m_pch] = (m_pp >= m_pd) ? 0 : m_pp;
        m_k[m_pch] = 0;
        m_pend = 1'b0;
      end else if (cfg_valid && !m_pend && int'(cfg_ch) < CH) begin
        m_pend = 1'b1;
        m_pch  = int'(cfg_ch);
        m_pn = longint'(cfg_num); m_pd = longint'(cfg_den); m_pp = longint'(cfg_phase);
      end
      lk_hist.push_back(locked);
      if (lk_hist.size() > L + 6) void'(lk_hist.pop_front());
      e.cen = w; e.run = runa; e.rdy = !m_pend;
    end
    sb.push_back(e);
  endtask

  task automatic cycle();
    step();
    @(posedge refclk);
    #2;
  endtask

  task automatic do_write(input int ch, input int n, input int d, input int p);
    int b = 0;
    while (m_pend && b < 2000) begin cycle(); b++; end
    if (m_pend) begin
      errors++;
      $display("FAIL write_wait: slot still busy after %0d cycles, expected free", b);
    end
    cfg_valid = 1'b1;
    cfg_ch = CHW'(ch); cfg_num = AW'(n); cfg_den = AW'(d); cfg_phase = AW'(p);
    cycle();
    cfg_valid = 1'b0;
  endtask

  // Monitor: compares the DUT after every edge against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge refclk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("cen", int'(cen), int'(e.cen));
        chk("running", int'(running), int'(e.run));
        chk("cfg_ready", int'(cfg_ready), int'(e.rdy));
        if (win) win_cnt += int'(cen[1]);
      end
    end
  end

  initial begin
    int off_len;
    rst_n = 1'b0; locked = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_num = '0; cfg_den = '0; cfg_phase = '0;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();

    // Configure while unlocked: each write applies on the next edge.
    do_write(0, 1, 3, 0);
    do_write(1, 3, 7, 0);
    do_write(2, 9, 5, 0);
    do_write(3, 5, 5, 0);
    repeat (2) cycle();

    locked = 1'b1;
    repeat (30) cycle();
    locked = 1'b0;
    repeat (6) cycle();

    // Lock bounce just before qualification.
    locked = 1'b1;
    repeat (L - 1) cycle();
    locked = 1'b0;
    cycle();
    locked = 1'b1;
    repeat (30) cycle();

    win = 1'b1;
    repeat (700) cycle();
    win = 1'b0;
    chk("ch1_pulses_700", win_cnt, 300);

    // Runtime reprogramming and corner values.
    cycle();
    do_write(0, 1, 2, 0);
    repeat (10) cycle();
    do_write(1, 4, 0, 3);
    repeat (4) cycle();
    do_write(2, 1, 4, 6);
    repeat (12) cycle();
    do_write(3, 2, 2, 0);
    repeat (6) cycle();

`ifdef CLK_EN_GEN_PAUSE_EN
    do_write(0, 1, 3, 0);
    repeat (7) cycle();
    pz = 1'b1;
    repeat (5) cycle();
    pz = 1'b0;
    repeat (10) cycle();
`endif

    // Random phase.
    off_len = 0;
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) rst_n = 1'b0;
      if (it == 1502) rst_n = 1'b1;
      if (off_len > 0) begin
        off_len--;
        if (off_len == 0) locked = 1'b1;
      end else if ($urandom_range(99) < 1) begin
        locked = 1'b0;
        off_len = $urandom_range(1, 25);
      end
`ifdef CLK_EN_GEN_PAUSE_EN
      pz = ($urandom_range(99) < 4);
`endif
      cfg_valid = ($urandom_range(99) < 25);
      cfg_ch    = CHW'($urandom_range(3));
      cfg_num   = AW'($urandom_range(12));
      case ($urandom_range(19))
        0, 1:    cfg_den = '0;
        2:       cfg_den = AW'($urandom_range(1, 200));
        default: cfg_den = AW'($urandom_range(1, 12));
      endcase
      cfg_phase = AW'($urandom_range(15));
      cycle();
    end
    cfg_valid = 1'b0;
    repeat (3) cycle();
    repeat (2) @(posedge refclk);
    #3;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
